hilo_div_unit: RTL and testbench
================================

// Module: hilo_div_unit
// PURPOSE
//  HI/LO register unit that receives the ALU's HI/LO write results (MULT/MULTU/MTHI/MTLO)
//  and supplies HI/LO read values back to the ALU's MFHI/MFLO inputs. Adds a multi-cycle
//  radix-2 restoring divider for DIV/DIVU that stalls the pipeline and writes HI/LO when done.
//  Sits in EX beside the ALU; its outputs drive the ALU's hialuin/loaluin.
// PARAMETERS
//  WIDTH   32   operand / HI / LO width; divider iterates WIDTH cycles
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  rst         in   1      synchronous reset, active-high
//  hi_we       in   1      write HI from ALU path (MULT/MULTU/MTHI)
//  lo_we       in   1      write LO from ALU path (MULT/MULTU/MTLO)
//  hi_wdata    in   WIDTH  ALU hialuout
//  lo_wdata    in   WIDTH  ALU loaluout
//  div_start   in   1      launch divide; sampled only in IDLE
//  div_signed  in   1      1=DIV, 0=DIVU; latched with div_start
//  div_a       in   WIDTH  dividend (rs)
//  div_b       in   WIDTH  divisor (rt)
//  flush       in   1      exception/flush: abort divide, suppress its writeback
//  div_stall   out  1      hold pipeline while divide in progress
//  div_done    out  1      1-cycle pulse, divider writing HI/LO this cycle
//  hi_rdata    out  WIDTH  current HI, to ALU hialuin
//  lo_rdata    out  WIDTH  current LO, to ALU loaluin
// BEHAVIOUR
//  Reset: HI=LO=0, state=IDLE, counter=0, div_stall=0, div_done=0.
//  HI/LO write: hi_we/lo_we update the register at the edge; independent enables.
//  Read bypass: hi_rdata = hi_we ? hi_wdata : HI (same for LO), combinational.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//   IDLE: div_start & ~flush & div_b!=0 -> latch |a|,|b| (abs only if div_signed), sign
//     flags, clear partial remainder, count=WIDTH-1 -> BUSY. div_b==0 -> DONE directly.
//   BUSY: per cycle shift {rem,quo} left 1; if rem>=|b| subtract, quo LSB=1.
//     count==0 -> DONE. div_start ignored.
//   DONE: div_done=1; HI<=remainder, LO<=quotient (signed fix-up applied) -> IDLE.
//  Signed fix-up: quotient negated iff sign(a)!=sign(b); remainder takes sign of a.
//  0x80000000 / -1 (signed): wraps, LO=0x80000000, HI=0; no trap.
//  Divide by zero: no iteration; DONE next cycle, LO=all ones, HI=div_a unchanged, no fix-up.
//  div_stall = (IDLE & div_start & ~flush) | BUSY; low in DONE so the pipeline advances.
//  Latency: start edge -> WIDTH BUSY cycles -> DONE cycle; stall high WIDTH+1 cycles.
//  Bypass in DONE: hi_rdata/lo_rdata show the divider result in the DONE cycle.
//  Collision: DONE writeback wins over hi_we/lo_we in the same cycle (ALU write dropped).
//  flush: BUSY or DONE -> IDLE next edge, HI/LO unchanged, div_done forced 0.
//   flush with div_start in IDLE: divide not launched.
//  rst mid-divide: immediate IDLE, HI=LO=0, no div_done.
// TESTING
//  1 reset 2 cycles -> HI=LO=0, div_stall=0, div_done=0; assert rst during BUSY -> same next cycle.
//  2 hi_we=1 hi_wdata=0x12345678 -> hi_rdata=0x12345678 same cycle; held after hi_we=0; LO unchanged.
//  3 DIVU 100/7 -> div_stall high 33 cycles, div_done at cycle 34: LO=14, HI=2.
//  4 DIV 0xFFFFFFF9(-7)/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
//  5 DIVU 5/0 -> div_done next cycle, LO=0xFFFFFFFF, HI=5; lo_we in that DONE cycle ignored.
//  6 HI=0xAA, DIVU 9/3, flush at BUSY cycle 10 -> IDLE, div_done never, HI=0xAA; new start accepted.

Source files
------------

// File: rtl/hilo_div_if.sv
// HI/LO unit bus: ALU write results, divide launch/control, and HI/LO read-back with stall status.
interface hilo_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hi_wdata;
  logic [WIDTH-1:0] lo_wdata;
  logic             div_start;
  logic             div_signed;
  logic [WIDTH-1:0] div_a;
  logic [WIDTH-1:0] div_b;
  logic             flush;
  logic             div_stall;
  logic             div_done;
  logic [WIDTH-1:0] hi_rdata;
  logic [WIDTH-1:0] lo_rdata;

  modport master (
    output hi_we, lo_we, hi_wdata, lo_wdata, div_start, div_signed, div_a, div_b, flush,
    input  div_stall, div_done, hi_rdata, lo_rdata
  );

  modport slave (
    input  hi_we, lo_we, hi_wdata, lo_wdata, div_start, div_signed, div_a, div_b, flush,
    output div_stall, div_done, hi_rdata, lo_rdata
  );
endinterface

// File: rtl/hilo_div_unit.sv
// HI/LO register pair with ALU write/read bypass and a multi-cycle radix-2 restoring divider
// that stalls the pipeline and writes HI (remainder) / LO (quotient) on completion.
module hilo_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  hilo_div_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [WIDTH:0]   rem_sh, rem_diff;
  logic [WIDTH-1:0] a_abs, b_abs, res_hi, res_lo;
  logic             launch, wb;

  assign launch = (state_q == StIdle) && bus.div_start && !bus.flush;
  assign wb     = (state_q == StDone) && !bus.flush;

  assign a_abs  = (bus.div_signed && bus.div_a[WIDTH-1]) ? -bus.div_a : bus.div_a;
  assign b_abs  = (bus.div_signed && bus.div_b[WIDTH-1]) ? -bus.div_b : bus.div_b;

  // Remainder gets one extra bit so divisors above 2^(WIDTH-1) compare correctly after shift.
  assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, dvs_q};

  assign res_lo = q_neg_q ? -quo_q : quo_q;
  assign res_hi = r_neg_q ? -rem_q : rem_q;

  assign bus.div_stall = launch || (state_q == StBusy);
  assign bus.div_done  = wb && !rst;
  assign bus.hi_rdata  = wb ? res_hi : (bus.hi_we ? bus.hi_wdata : hi_q);
  assign bus.lo_rdata  = wb ? res_lo : (bus.lo_we ? bus.lo_wdata : lo_q);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      StIdle: begin
        if (launch) begin
          if (bus.div_b == '0) begin
            // Divide by zero: canned result, flags cleared so no sign fix-up is applied.
            rem_d   = bus.div_a;
            quo_d   = '1;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = StDone;
          end else begin
            rem_d   = '0;
            quo_d   = a_abs;
            dvs_d   = b_abs;
            q_neg_d = bus.div_signed && (bus.div_a[WIDTH-1] ^ bus.div_b[WIDTH-1]);
            r_neg_d = bus.div_signed && bus.div_a[WIDTH-1];
            cnt_d   = CntW'(WIDTH - 1);
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (!rem_diff[WIDTH]) begin
          rem_d = rem_diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
        if (bus.flush) state_d = StIdle;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Divider writeback has priority over a same-cycle ALU write.
    if (wb) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end else begin
      if (bus.hi_we) hi_d = bus.hi_wdata;
      if (bus.lo_we) lo_d = bus.lo_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hilo_div_unit.sv
// Randomized self-checking bench for hilo_div_unit against an arithmetic HI/LO/divide model.
module tb_hilo_div_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] hi_m, lo_m;

  hilo_div_if #(.WIDTH(32)) bus ();

  hilo_div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: MIPS-style DIV/DIVU, truncating toward zero, remainder follows dividend.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                  output logic [31:0] hi, output logic [31:0] lo);
    int signed sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else if (!sgn) begin
      lo = a / b;
      hi = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = 32'h8000_0000;
      hi = 32'd0;
    end else begin
      lo = sa / sb;
      hi = sa % sb;
    end
  endfunction

  task automatic alu_write(input logic hw, input logic lw, input logic [31:0] hd,
                           input logic [31:0] ld);
    bus.hi_we = hw; bus.lo_we = lw; bus.hi_wdata = hd; bus.lo_wdata = ld;
    #1;
    check("hi_bypass", bus.hi_rdata, hw ? hd : hi_m);
    check("lo_bypass", bus.lo_rdata, lw ? ld : lo_m);
    tick();
    if (hw) hi_m = hd;
    if (lw) lo_m = ld;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    #1;
    check("hi_held", bus.hi_rdata, hi_m);
    check("lo_held", bus.lo_rdata, lo_m);
  endtask

  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic [31:0] eh, el;
    int stalls;
    bit seen;
    ref_div(a, b, sgn, eh, el);
    bus.div_start = 1'b1; bus.div_a = a; bus.div_b = b; bus.div_signed = sgn;
    #1;
    check("stall_launch", 32'(bus.div_stall), 32'd1);
    tick();
    stalls = 1;
    seen = 0;
    // Operands must have been latched; scramble them while busy.
    bus.div_a = $urandom; bus.div_b = $urandom; bus.div_signed = 1'($urandom);
    for (int i = 0; i < 40 && !seen; i++) begin
      #1;
      if (bus.div_done) begin
        seen = 1;
        check("stall_cycles", 32'(stalls), (b == 32'd0) ? 32'd1 : 32'd33);
        check("stall_in_done", 32'(bus.div_stall), 32'd0);
        bus.div_start = 1'b0;
        bus.hi_we = 1'($urandom); bus.lo_we = 1'($urandom);
        bus.hi_wdata = $urandom; bus.lo_wdata = $urandom;
        #1;
        check("hi_done_bypass", bus.hi_rdata, eh);
        check("lo_done_bypass", bus.lo_rdata, el);
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        hi_m = eh; lo_m = el;
        #1;
        check("hi_after_div", bus.hi_rdata, hi_m);
        check("lo_after_div", bus.lo_rdata, lo_m);
        check("done_pulse_1cyc", 32'(bus.div_done), 32'd0);
      end else begin
        if (bus.div_stall) stalls++;
        bus.div_start = 1'($urandom);
        tick();
      end
    end
    bus.div_start = 1'b0;
    if (!seen) check("div_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    int dones = 0;
    for (int i = 0; i < cycles; i++) begin
      #1;
      if (bus.div_done || bus.div_stall) dones++;
      tick();
    end
    check(tag, 32'(dones), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    bus.hi_we = 0; bus.lo_we = 0; bus.hi_wdata = 0; bus.lo_wdata = 0;
    bus.div_start = 0; bus.div_signed = 0; bus.div_a = 0; bus.div_b = 0; bus.flush = 0;
    hi_m = 0; lo_m = 0;

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_hi", bus.hi_rdata, 32'd0);
    check("rst_lo", bus.lo_rdata, 32'd0);
    check("rst_stall", 32'(bus.div_stall), 32'd0);
    check("rst_done", 32'(bus.div_done), 32'd0);

    alu_write(1'b1, 1'b0, 32'h1234_5678, 32'hDEAD_BEEF);

    do_div(32'd100, 32'd7, 1'b0);
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_div(32'd5, 32'd0, 1'b0);
    do_div(32'hFFFF_FFF0, 32'd0, 1'b1);
    do_div(32'hFFFF_FFFF, 32'h8000_0001, 1'b0);

    // Flush in the tenth busy cycle aborts without writeback.
    alu_write(1'b1, 1'b0, 32'h0000_00AA, 32'd0);
    bus.div_start = 1'b1; bus.div_a = 32'd9; bus.div_b = 32'd3; bus.div_signed = 1'b0;
    tick();
    bus.div_start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    bus.flush = 1'b1;
    #1;
    check("flush_no_done", 32'(bus.div_done), 32'd0);
    tick();
    bus.flush = 1'b0;
    watch_quiet("flush_quiet", 40);
    #1;
    check("flush_hi_kept", bus.hi_rdata, 32'h0000_00AA);
    check("flush_lo_kept", bus.lo_rdata, lo_m);

    // Flush together with start in idle: nothing launched.
    bus.div_start = 1'b1; bus.flush = 1'b1; bus.div_a = 32'd50; bus.div_b = 32'd5;
    #1;
    check("flush_start_stall", 32'(bus.div_stall), 32'd0);
    tick();
    bus.div_start = 1'b0; bus.flush = 1'b0;
    watch_quiet("flush_start_quiet", 40);
    do_div(32'd9, 32'd3, 1'b0);

    for (int n = 0; n < 20; n++) begin
      a = $urandom;
      case ($urandom % 5)
        0: b = 32'd0;
        1: b = $urandom % 16;
        2: b = $urandom;
        3: b = 32'hFFFF_FFFF;
        default: b = -($urandom % 100);
      endcase
      if ($urandom % 6 == 0) a = 32'h8000_0000;
      if ($urandom % 2 == 0)
        alu_write(1'($urandom), 1'($urandom), $urandom, $urandom);
      do_div(a, b, 1'($urandom));
    end

    // Reset in the middle of a divide.
    bus.div_start = 1'b1; bus.div_a = 32'd1000; bus.div_b = 32'd3; bus.div_signed = 1'b0;
    tick();
    bus.div_start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    check("rst_busy_done", 32'(bus.div_done), 32'd0);
    tick();
    rst = 1'b0;
    hi_m = 0; lo_m = 0;
    #1;
    check("rst_busy_hi", bus.hi_rdata, 32'd0);
    check("rst_busy_lo", bus.lo_rdata, 32'd0);
    check("rst_busy_stall", 32'(bus.div_stall), 32'd0);
    watch_quiet("rst_busy_quiet", 40);
    do_div(32'hFFFF_FF9C, 32'd7, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
